// File: rtl/beam_sort_pkg.sv
// -----------------------------------------------------------------------------
// beam_sort_pkg
// Shared types and constants for the beam top-K selector.
//   beam_ent_t : one sorted-list entry {vld, pwr, idx}
//   state_t    : selector FSM states
//   IDX_W      : beam index width (codebook depth up to 256)
//   ENT_PWR_W  : power width stored in a list entry (widest supported PWR_W)
// -----------------------------------------------------------------------------
package beam_sort_pkg;

    localparam int IDX_W     = 8;
    localparam int ENT_PWR_W = 32;

    typedef struct packed {
        logic                 vld;
        logic [ENT_PWR_W-1:0] pwr;
        logic [IDX_W-1:0]     idx;
    } beam_ent_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // A slot ranks at or above a new sample when it is valid and its power is
    // not smaller. Equality counts as "above" so earlier arrivals win ties.
    function automatic logic ent_ge(input beam_ent_t e, input logic [ENT_PWR_W-1:0] p);
        return e.vld && (e.pwr >= p);
    endfunction

endpackage

// File: rtl/beam_sort_slot.sv
// -----------------------------------------------------------------------------
// beam_sort_slot
// One position of the parallel-compare insertion list.
// Ports:
//   i_clk, i_reset   : clock, synchronous active-low reset
//   i_clr            : empty the slot (end of RBG)
//   i_ins            : a new sample is being inserted into the list
//   i_new            : the new entry
//   i_up_ent/i_up_ge : entry and compare flag of the slot above
//   o_ent            : current slot contents
//   o_ge             : this slot ranks at or above the new sample
// -----------------------------------------------------------------------------
module beam_sort_slot
    import beam_sort_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      i_clr,
    input  logic      i_ins,
    input  beam_ent_t i_new,
    input  beam_ent_t i_up_ent,
    input  logic      i_up_ge,
    output beam_ent_t o_ent,
    output logic      o_ge
);

    beam_ent_t ent_q, ent_d;

    assign o_ge  = ent_ge(ent_q, i_new.pwr);
    assign o_ent = ent_q;

    // The ge flags down the list form a run of 1s then 0s. The first slot
    // whose flag is 0 (upper flag 1) takes the new entry; slots below it take
    // their upper neighbour, which shifts the tail down by one.
    always_comb begin
        ent_d = ent_q;
        if (i_clr) begin
            ent_d = '0;
        end else if (i_ins && !o_ge) begin
            ent_d = i_up_ge ? i_new : i_up_ent;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

endmodule

// File: rtl/beam_topk_sel.sv
// -----------------------------------------------------------------------------
// beam_topk_sel
// Keeps a running top-BEAM list of beam powers per RBG and, at the end of the
// RBG, emits the BEAM strongest beam indices (strongest first) with a one-cycle
// load strobe for the codeword selection stage.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-low reset
//   i_enable        : low freezes all state and drops o_ready
//   i_pwr_vld/data/last : beam-power stream; beam index = arrival order
//   o_ready         : sample accepted on i_pwr_vld & o_ready
//   o_beam_idx      : sorted indices, entry 0 strongest; held between strobes
//   o_rbg_load      : one-cycle strobe, o_beam_idx new on this cycle
//   o_len_err       : pulses with o_rbg_load when RBG length != BEAMS
//   o_beam_pwr      : sorted powers (only with BEAM_PWR_OUT_EN defined)
// Build option: define BEAM_PWR_OUT_EN to add o_beam_pwr.
// PWR_W must not exceed ENT_PWR_W.
// -----------------------------------------------------------------------------
module beam_topk_sel
    import beam_sort_pkg::*;
#(
    parameter int BEAMS = 64,
    parameter int BEAM  = 16,
    parameter int PWR_W = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_pwr_vld,
    input  logic [PWR_W-1:0]             i_pwr_data,
    input  logic                         i_pwr_last,
    output logic                         o_ready,
    output logic [BEAM-1:0][IDX_W-1:0]   o_beam_idx,
    output logic                         o_rbg_load,
    output logic                         o_len_err
`ifdef BEAM_PWR_OUT_EN
    ,
    output logic [BEAM-1:0][PWR_W-1:0]   o_beam_pwr
`endif
);

    // cnt never exceeds BEAMS-1: that sample always terminates the RBG.
    localparam int CNT_W = (BEAMS > 1) ? $clog2(BEAMS) : 1;

    state_t                     state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       err_pend_q;
    logic                       rbg_load_q;
    logic                       len_err_q;
    logic [BEAM-1:0][IDX_W-1:0] beam_idx_q;
`ifdef BEAM_PWR_OUT_EN
    logic [BEAM-1:0][PWR_W-1:0] beam_pwr_q;
`endif

    beam_ent_t   new_ent;
    beam_ent_t   slot_ent [BEAM];
    beam_ent_t   up_ent   [BEAM];
    logic        up_ge    [BEAM];
    logic [BEAM-1:0] ge;

    logic accept, ins, clr, last_cnt, term, len_bad, list_full_above;

    assign o_ready  = i_reset & i_enable & (state_q != EMIT);
    assign accept   = i_pwr_vld & o_ready;
    assign last_cnt = (cnt_q == CNT_W'(BEAMS - 1));
    assign term     = i_pwr_last | last_cnt;
    // Exactly one of "last flag" and "count reached BEAMS-1" is a length error.
    assign len_bad  = i_pwr_last ^ last_cnt;

    // When every slot ranks at or above the sample it is dropped; skip the
    // list update entirely in that case.
    assign list_full_above = &ge;
    assign ins = accept & ~list_full_above;
    // The list empties on the edge that copies it to the outputs.
    assign clr = i_enable & (state_q == EMIT);

    always_comb begin
        new_ent     = '0;
        new_ent.vld = 1'b1;
        new_ent.pwr = ENT_PWR_W'(i_pwr_data);
        new_ent.idx = IDX_W'(cnt_q);
    end

    for (genvar k = 0; k < BEAM; k++) begin : g_slot
        if (k == 0) begin : g_head
            // The head has no upper neighbour; a sample that beats it lands here.
            assign up_ent[k] = '0;
            assign up_ge[k]  = 1'b1;
        end else begin : g_body
            assign up_ent[k] = slot_ent[k-1];
            assign up_ge[k]  = ge[k-1];
        end

        beam_sort_slot u_slot (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_clr    (clr),
            .i_ins    (ins),
            .i_new    (new_ent),
            .i_up_ent (up_ent[k]),
            .i_up_ge  (up_ge[k]),
            .o_ent    (slot_ent[k]),
            .o_ge     (ge[k])
        );
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            rbg_load_q <= 1'b0;
            len_err_q  <= 1'b0;
            for (int i = 0; i < BEAM; i++) begin
                beam_idx_q[i] <= IDX_W'(i);
            end
`ifdef BEAM_PWR_OUT_EN
            beam_pwr_q <= '0;
`endif
        end else begin
            // Strobes are single-cycle and never stretched by i_enable.
            rbg_load_q <= 1'b0;
            len_err_q  <= 1'b0;
            if (i_enable) begin
                case (state_q)
                    IDLE, COLLECT: begin
                        if (accept) begin
                            cnt_q <= cnt_q + 1'b1;
                            if (term) begin
                                state_q    <= EMIT;
                                err_pend_q <= len_bad;
                            end else begin
                                state_q <= COLLECT;
                            end
                        end
                    end
                    EMIT: begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        rbg_load_q <= 1'b1;
                        len_err_q  <= err_pend_q;
                        err_pend_q <= 1'b0;
                        // Unfilled slots fall back to the consumer's default map.
                        for (int i = 0; i < BEAM; i++) begin
                            beam_idx_q[i] <= slot_ent[i].vld ? slot_ent[i].idx : IDX_W'(i);
`ifdef BEAM_PWR_OUT_EN
                            beam_pwr_q[i] <= slot_ent[i].vld ? slot_ent[i].pwr[PWR_W-1:0] : '0;
`endif
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_beam_idx = beam_idx_q;
    assign o_rbg_load = rbg_load_q;
    assign o_len_err  = len_err_q;
`ifdef BEAM_PWR_OUT_EN
    assign o_beam_pwr = beam_pwr_q;
`endif

endmodule

// File: tb/tb_beam_topk_sel.sv
// -----------------------------------------------------------------------------
// tb_beam_topk_sel
// Directed bench for beam_topk_sel. Each terminating RBG pushes its expected
// sorted index vector, error flag and strobe cycle onto a scoreboard; every
// strobe from the DUT pops and compares one entry.
// -----------------------------------------------------------------------------
module tb_beam_topk_sel;

    localparam int BEAMS = 64;
    localparam int BEAM  = 16;
    localparam int PWR_W = 32;

    logic                   i_clk = 1'b0;
    logic                   i_reset = 1'b0;
    logic                   i_enable = 1'b0;
    logic                   i_pwr_vld = 1'b0;
    logic [PWR_W-1:0]       i_pwr_data = '0;
    logic                   i_pwr_last = 1'b0;
    logic                   o_ready;
    logic [BEAM-1:0][7:0]   o_beam_idx;
    logic                   o_rbg_load;
    logic                   o_len_err;
`ifdef BEAM_PWR_OUT_EN
    logic [BEAM-1:0][PWR_W-1:0] o_beam_pwr;
`endif

    beam_topk_sel #(.BEAMS(BEAMS), .BEAM(BEAM), .PWR_W(PWR_W)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_pwr_vld  (i_pwr_vld),
        .i_pwr_data (i_pwr_data),
        .i_pwr_last (i_pwr_last),
        .o_ready    (o_ready),
        .o_beam_idx (o_beam_idx),
        .o_rbg_load (o_rbg_load),
        .o_len_err  (o_len_err)
`ifdef BEAM_PWR_OUT_EN
        ,
        .o_beam_pwr (o_beam_pwr)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [BEAM-1:0][7:0] idx;
        logic                 err;
        int                   due;
    } exp_t;

    exp_t                 sb[$];
    int                   ncmp = 0;
    int                   nfail = 0;
    int                   cyc_n = 0;
    logic [BEAM-1:0][7:0] ident;
    logic [BEAM-1:0][7:0] last_idx;
    logic [31:0]          pw[$];
    logic [31:0]          pw2[$];

    task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: stable selection of the BEAM largest powers, earlier index
    // first on ties; unfilled positions default to their own index.
    function automatic exp_t model(input logic [31:0] p[$], input logic err);
        exp_t e;
        bit   used[256];
        int   best;
        foreach (used[j]) used[j] = 1'b0;
        for (int k = 0; k < BEAM; k++) begin
            best = -1;
            for (int j = 0; j < p.size(); j++) begin
                if (!used[j] && (best < 0 || p[j] > p[best])) best = j;
            end
            if (best >= 0) begin
                used[best] = 1'b1;
                e.idx[k]   = 8'(best);
            end else begin
                e.idx[k] = 8'(k);
            end
        end
        e.err = err;
        e.due = 0;
        return e;
    endfunction

    // One clock; sample outputs 1 time unit after the edge and service the
    // scoreboard.
    task automatic cyc();
        exp_t e;
        @(posedge i_clk);
        #1;
        cyc_n++;
        if (o_rbg_load) begin
            if (sb.size() == 0) begin
                chk1("unexpected_strobe", o_rbg_load, 1'b0);
            end else begin
                e = sb.pop_front();
                chkv("beam_idx", o_beam_idx, e.idx);
                chk1("len_err", o_len_err, e.err);
                chki("strobe_cycle", cyc_n, e.due);
                last_idx = e.idx;
            end
        end else begin
            chk1("len_err_without_strobe", o_len_err, 1'b0);
            if (sb.size() > 0 && sb[0].due <= cyc_n) begin
                e = sb.pop_front();
                chk1("missing_strobe", o_rbg_load, 1'b1);
            end
        end
    endtask

    // Stream one RBG; optionally drop i_enable for 3 cycles before sample gap_at.
    task automatic send(input logic [31:0] p[$], input bit last_end, input int gap_at);
        int   n;
        int   g;
        bit   a;
        exp_t e;
        n = p.size();
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                i_enable   = 1'b0;
                i_pwr_vld  = 1'b1;
                i_pwr_data = p[i];
                i_pwr_last = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    #1;
                    chk1("ready_while_disabled", o_ready, 1'b0);
                    cyc();
                end
                i_enable = 1'b1;
            end
            i_pwr_vld  = 1'b1;
            i_pwr_data = p[i];
            i_pwr_last = last_end && (i == n - 1);
            #1;
            a = 1'b0;
            g = 0;
            while (!a && g < 20) begin
                a = o_ready;
                cyc();
                g++;
            end
            if (!a) chk1("accept_timeout", o_ready, 1'b1);
        end
        i_pwr_vld  = 1'b0;
        i_pwr_last = 1'b0;
        if (last_end || n == BEAMS) begin
            e     = model(p, last_end ? (n != BEAMS) : 1'b1);
            e.due = cyc_n + 1;
            sb.push_back(e);
        end
    endtask

    // After a standalone RBG: one bubble, one strobe cycle, then outputs hold.
    task automatic finish_rbg();
        chk1("ready_in_emit", o_ready, 1'b0);
        cyc();
        chk1("ready_after_emit", o_ready, 1'b1);
        cyc();
        chk1("strobe_one_cycle", o_rbg_load, 1'b0);
        chkv("idx_hold", o_beam_idx, last_idx);
    endtask

    initial begin
        for (int i = 0; i < BEAM; i++) ident[i] = 8'(i);
        last_idx = ident;

        // Reset state
        i_reset  = 1'b0;
        i_enable = 1'b1;
        cyc();
        cyc();
        chk1("reset_ready", o_ready, 1'b0);
        chk1("reset_load", o_rbg_load, 1'b0);
        chk1("reset_len_err", o_len_err, 1'b0);
        chkv("reset_idx", o_beam_idx, ident);
        i_reset = 1'b1;
        cyc();
        chk1("ready_after_reset", o_ready, 1'b1);

        // Ascending powers
        pw.delete();
        for (int i = 0; i < BEAMS; i++) pw.push_back(32'(i));
        send(pw, 1'b1, -1);
        finish_rbg();

        // Descending powers
        pw.delete();
        for (int i = 0; i < BEAMS; i++) pw.push_back(32'(BEAMS - 1 - i));
        send(pw, 1'b1, -1);
        finish_rbg();

        // All equal: ties keep arrival order
        pw.delete();
        for (int i = 0; i < BEAMS; i++) pw.push_back(32'h1000);
        send(pw, 1'b1, -1);
        finish_rbg();

        // Short RBG of 10: unfilled slots default, length error
        pw.delete();
        for (int i = 0; i < 10; i++) pw.push_back(32'(10 * i));
        send(pw, 1'b1, -1);
        finish_rbg();

        // Full RBG without last flag: terminates at BEAMS, length error
        pw.delete();
        for (int i = 0; i < BEAMS; i++) pw.push_back($urandom);
        send(pw, 1'b0, -1);
        finish_rbg();

        // Back-to-back RBGs, enable dropped mid-first, second reversed
        pw.delete();
        pw2.delete();
        for (int i = 0; i < BEAMS; i++) pw.push_back($urandom_range(0, 4095));
        for (int i = 0; i < BEAMS; i++) pw2.push_back(pw[BEAMS - 1 - i]);
        send(pw, 1'b1, 20);
        send(pw2, 1'b1, -1);
        finish_rbg();

        // Reset in the middle of an RBG
        pw.delete();
        for (int i = 0; i < 30; i++) pw.push_back($urandom);
        send(pw, 1'b0, -1);
        i_reset = 1'b0;
        cyc();
        chk1("midreset_load", o_rbg_load, 1'b0);
        chk1("midreset_ready", o_ready, 1'b0);
        chkv("midreset_idx", o_beam_idx, ident);
        i_reset = 1'b1;
        cyc();
        chk1("midreset_ready_after", o_ready, 1'b1);
        chkv("midreset_idx_after", o_beam_idx, ident);
        last_idx = ident;

        // Full RBG after the reset must index from 0
        pw.delete();
        for (int i = 0; i < BEAMS; i++) pw.push_back($urandom_range(0, 255));
        send(pw, 1'b1, -1);
        finish_rbg();

        cyc();
        chki("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
